// File: rtl/usb_bit_stuff_unit_pkg.sv
// usb_pkg
//   Shared types and constants for the USB bit stuffer/unstuffer slice.
//   stuff_state_t : IDLE / RUN / STUFF / CHECK state encoding
//   USB_RUN_LEN   : default number of consecutive 1s that trigger a stuff slot
package usb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STUFF = 2'd2,
    CHECK = 2'd3
  } stuff_state_t;

  localparam int USB_RUN_LEN = 6;

endpackage

// File: rtl/usb_bit_stuff_unit_if.sv
// usb_bit_stuff_unit_if
//   Serial bit-stream bundle between a bit source and the stuff unit.
//   Source -> unit : start, last, bit_in, hold_in, ack
//   Unit -> sink   : bit_out, stall, last_out, active, stuff_ok
//                    (+ err_count when USB_STUFF_ERR_CNT_EN is defined)
//   master modport : the side driving the bit stream (testbench / encoder)
//   slave modport  : the stuff unit itself
interface usb_bit_stuff_unit_if
`ifdef USB_STUFF_ERR_CNT_EN
  #(parameter int ERR_CNT_W = 8)
`endif
  ;

  logic start;
  logic last;
  logic bit_in;
  logic hold_in;
  logic ack;
  logic bit_out;
  logic stall;
  logic last_out;
  logic active;
  logic stuff_ok;
`ifdef USB_STUFF_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output start, last, bit_in, hold_in, ack,
    input  bit_out, stall, last_out, active, stuff_ok, err_count
  );

  modport slave (
    input  start, last, bit_in, hold_in, ack,
    output bit_out, stall, last_out, active, stuff_ok, err_count
  );
`else
  modport master (
    output start, last, bit_in, hold_in, ack,
    input  bit_out, stall, last_out, active, stuff_ok
  );

  modport slave (
    input  start, last, bit_in, hold_in, ack,
    output bit_out, stall, last_out, active, stuff_ok
  );
`endif

endinterface

// File: rtl/usb_bit_stuff_unit_run_counter.sv
// usb_run_counter
//   Counts consecutive 1s of the bit stream.
//   clk, rst : clock, asynchronous active-high reset
//   inc      : an accepted 1 this cycle
//   clr      : restart the count (combined with inc the count restarts at 1)
//   hold     : freeze the count
//   run_done : the 1 accepted this cycle completes a run of RUN_LEN
module usb_run_counter
  import usb_pkg::*;
#(
  parameter int RUN_LEN = USB_RUN_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  input  logic hold,
  output logic run_done
);

  localparam int CNT_W = $clog2(RUN_LEN + 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Clear takes effect before the increment so that clr+inc loads 1.
  always_comb begin
    count_d = clr ? '0 : count_q;
    if (inc) begin
      count_d = count_d + CNT_W'(1);
    end
  end

  assign run_done = inc & (count_d == CNT_W'(RUN_LEN));

  // Count register, frozen while downstream holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (!hold) begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/usb_bit_stuff_unit.sv
// usb_bit_stuff_unit
//   Parametrised USB bit stuffer (UNSTUFF=0, send path) / unstuffer and
//   stuff checker (UNSTUFF=1, receive path).
//   clk, rst : clock, asynchronous active-high reset
//   bus      : usb_bit_stuff_unit_if.slave
//              in : start, last, bit_in, hold_in, ack
//              out: bit_out, stall, last_out, active, stuff_ok
//   Optional feature macro USB_STUFF_ERR_CNT_EN adds bus.err_count, a
//   saturating count of stuff violations cleared only by rst.
module usb_bit_stuff_unit
  import usb_pkg::*;
#(
  parameter int RUN_LEN = USB_RUN_LEN,
  parameter bit UNSTUFF = 1'b0
`ifdef USB_STUFF_ERR_CNT_EN
  ,
  parameter int ERR_CNT_W = 8
`endif
) (
  input logic clk,
  input logic rst,
  usb_bit_stuff_unit_if.slave bus
);

  stuff_state_t state_q, state_d;

  logic bit_out_q, bit_out_d;
  logic last_out_q, last_out_d;
  logic active_q, active_d;
  logic stuff_ok_q, stuff_ok_d;
  logic stall_q, stall_d;
  logic last_pend_q, last_pend_d;

  logic take;
  logic data_take;
  logic check_take;
  logic violation;
  logic run_inc;
  logic run_clr;
  logic run_done;

  // STUFF never samples the input; in CHECK the sampled bit is the stuff slot
  // unless start restarts the packet.
  assign take       = ~bus.hold_in & (state_q != STUFF);
  assign data_take  = take & (bus.start | (state_q == RUN));
  assign check_take = take & ~bus.start & (state_q == CHECK);
  assign violation  = check_take & bus.bit_in;

  assign run_inc = (data_take | check_take) & bus.bit_in;
  assign run_clr = (data_take & (bus.start | ~bus.bit_in)) | check_take
                 | (state_q == STUFF);

  usb_run_counter #(
    .RUN_LEN (RUN_LEN)
  ) u_run_counter (
    .clk      (clk),
    .rst      (rst),
    .inc      (run_inc),
    .clr      (run_clr),
    .hold     (bus.hold_in),
    .run_done (run_done)
  );

  // State register; the whole unit freezes while downstream holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else if (!bus.hold_in) begin
      state_q <= state_d;
    end
  end

  // Next state. On the receive path a run completed by the last bit ends the
  // packet, because no stuff slot will follow it.
  always_comb begin
    state_d = state_q;
    if (data_take) begin
      if (run_done && !(UNSTUFF && bus.last)) begin
        state_d = UNSTUFF ? CHECK : STUFF;
      end else begin
        state_d = bus.last ? IDLE : RUN;
      end
    end else if (check_take) begin
      state_d = bus.last ? IDLE : RUN;
    end else if (state_q == STUFF) begin
      state_d = last_pend_q ? IDLE : RUN;
    end
  end

  // Output/datapath next values. On the send path a last bit that completes
  // a run is parked in last_pend so last_out travels with the trailing 0.
  always_comb begin
    bit_out_d   = bit_out_q;
    last_out_d  = 1'b0;
    stall_d     = 1'b0;
    stuff_ok_d  = stuff_ok_q;
    last_pend_d = last_pend_q;
    active_d    = active_q;
    if (last_out_q) begin
      active_d = 1'b0;
    end
    if (bus.ack) begin
      stuff_ok_d = 1'b1;
    end
    if (take && bus.start) begin
      stuff_ok_d = 1'b1;
      active_d   = 1'b1;
    end
    if (data_take) begin
      bit_out_d   = bus.bit_in;
      last_pend_d = bus.last & run_done & ~UNSTUFF;
      last_out_d  = bus.last & ~(run_done & ~UNSTUFF);
    end else if (check_take) begin
      stall_d    = 1'b1;
      last_out_d = bus.last;
      if (violation) begin
        stuff_ok_d = 1'b0;
      end
    end else if (state_q == STUFF) begin
      bit_out_d   = 1'b0;
      last_out_d  = last_pend_q;
      last_pend_d = 1'b0;
    end
  end

  // Output and bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_out_q   <= 1'b0;
      last_out_q  <= 1'b0;
      active_q    <= 1'b0;
      stuff_ok_q  <= 1'b1;
      stall_q     <= 1'b0;
      last_pend_q <= 1'b0;
    end else if (!bus.hold_in) begin
      bit_out_q   <= bit_out_d;
      last_out_q  <= last_out_d;
      active_q    <= active_d;
      stuff_ok_q  <= stuff_ok_d;
      stall_q     <= stall_d;
      last_pend_q <= last_pend_d;
    end
  end

  assign bus.bit_out  = bit_out_q;
  assign bus.last_out = last_out_q;
  assign bus.active   = active_q;
  assign bus.stuff_ok = stuff_ok_q;
  assign bus.stall    = UNSTUFF ? stall_q : ((state_q == STUFF) | bus.hold_in);

`ifdef USB_STUFF_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  // Saturating violation counter, survives start and ack.
  always_comb begin
    err_count_d = err_count_q;
    if (violation && (err_count_q != {ERR_CNT_W{1'b1}})) begin
      err_count_d = err_count_q + ERR_CNT_W'(1);
    end
  end

  // Violation counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign bus.err_count = err_count_q;
`endif

endmodule
